// File: rtl/pc_redirect_unit.sv
// Program counter and fetch-redirect stage.
// Picks the next fetch address: sequential, branch or jump. Holds the PC
// while stalled, buffers a redirect that arrives during a stall, and issues a
// one-cycle IF/ID flush plus a saturating redirect counter.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             PCSrc,
    input  logic [31:0]      BranchTarget,
    input  logic             Jump,
    input  logic [31:0]      JumpTarget,
    input  logic             Stall,
    output logic [31:0]      PC,
    output logic [31:0]      PCPlus4,
    output logic             FetchValid,
    output logic             Flush,
    output logic [CNT_W-1:0] RedirectCount
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [31:0]        r_pc, w_pc_nxt;
    logic               r_pend_v, w_pend_v_nxt;
    logic [31:0]        r_pend_t, w_pend_t_nxt;
    logic               r_flush, w_flush_nxt;
    logic               r_fv, w_fv_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

    logic               w_req;
    logic [31:0]        w_tgt;
    logic [31:0]        w_redir_tgt;

    // Jump outranks the branch; a live request outranks a buffered one.
    assign w_req       = Jump | PCSrc;
    assign w_tgt       = Jump ? JumpTarget : BranchTarget;
    assign w_redir_tgt = w_req ? w_tgt : r_pend_t;

    // Next-state and next-output decode for the fetch sequencer.
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_pend_v_nxt = r_pend_v;
        w_pend_t_nxt = r_pend_t;
        w_flush_nxt  = 1'b0;
        w_fv_nxt     = r_fv;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
                w_fv_nxt    = 1'b1;
            end
            ST_RUN, ST_REDIR: begin
                w_state_nxt = ST_RUN;
                w_fv_nxt    = 1'b1;
                if (Stall) begin
                    if (w_req) begin
                        w_pend_v_nxt = 1'b1;
                        w_pend_t_nxt = w_tgt;
                    end
                end else if (w_req || r_pend_v) begin
                    w_pc_nxt     = {w_redir_tgt[31:2], 2'b00};
                    w_pend_v_nxt = 1'b0;
                    w_flush_nxt  = 1'b1;
                    w_fv_nxt     = 1'b0;
                    w_state_nxt  = ST_REDIR;
                    if (r_cnt != '1) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    w_pc_nxt = r_pc + 32'd4;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
                w_fv_nxt    = 1'b0;
            end
        endcase
    end

    // State, PC, pending buffer and registered outputs; reset wins over all.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state  <= ST_BOOT;
            r_pc     <= RESET_PC;
            r_pend_v <= 1'b0;
            r_pend_t <= '0;
            r_flush  <= 1'b0;
            r_fv     <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_pend_v <= w_pend_v_nxt;
            r_pend_t <= w_pend_t_nxt;
            r_flush  <= w_flush_nxt;
            r_fv     <= w_fv_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign PC            = r_pc;
    assign PCPlus4       = r_pc + 32'd4;
    assign FetchValid    = r_fv;
    assign Flush         = r_flush;
    assign RedirectCount = r_cnt;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Testbench for pc_redirect_unit: directed scenarios plus a randomized run,
// all checked against a cycle-level behavioural model of the fetch rules.
module tb_pc_redirect_unit;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic        Jump = 1'b0;
    logic [31:0] JumpTarget = '0;
    logic        Stall = 1'b0;
    logic [31:0] PC, PCPlus4, PC2, PCPlus4_2;
    logic        FetchValid, Flush, FetchValid2, Flush2;
    logic [15:0] RedirectCount;
    logic [1:0]  RedirectCount2;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_fv, m_flush, m_boot, m_pv;
    logic [31:0] m_pt;
    int unsigned m_cnt, m_cnt2;

    always #5 Clk = ~Clk;

    pc_redirect_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .Clk(Clk), .Rst(Rst), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget), .Stall(Stall),
        .PC(PC), .PCPlus4(PCPlus4), .FetchValid(FetchValid), .Flush(Flush),
        .RedirectCount(RedirectCount)
    );

    pc_redirect_unit #(.RESET_PC(32'h0), .CNT_W(2)) dut2 (
        .Clk(Clk), .Rst(Rst), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget), .Stall(Stall),
        .PC(PC2), .PCPlus4(PCPlus4_2), .FetchValid(FetchValid2), .Flush(Flush2),
        .RedirectCount(RedirectCount2)
    );

    // Drive one cycle of inputs, advance the model at the edge, settle.
    task automatic tick(input logic rst, input logic stall, input logic pcsrc,
                        input logic [31:0] bt, input logic jump, input logic [31:0] jt);
        logic        req;
        logic [31:0] tgt;
        Rst = rst; Stall = stall; PCSrc = pcsrc; BranchTarget = bt;
        Jump = jump; JumpTarget = jt;
        @(posedge Clk);
        req = jump | pcsrc;
        tgt = jump ? jt : bt;
        if (!rst) begin
            m_pc = 32'h0; m_fv = 0; m_flush = 0; m_boot = 1; m_pv = 0;
            m_pt = '0; m_cnt = 0; m_cnt2 = 0;
        end else if (m_boot) begin
            m_boot = 0; m_fv = 1; m_flush = 0;
        end else if (stall) begin
            if (req) begin m_pv = 1; m_pt = tgt; end
            m_flush = 0; m_fv = 1;
        end else if (req || m_pv) begin
            m_pc = (req ? tgt : m_pt) & 32'hFFFF_FFFC;
            m_pv = 0; m_flush = 1; m_fv = 0;
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end else begin
            m_pc = m_pc + 32'd4; m_flush = 0; m_fv = 1;
        end
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] exp_pc[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", PC); end
        checks++; if (FetchValid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b exp 0", FetchValid); end
        checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b exp 0", Flush); end
        checks++; if (RedirectCount !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", RedirectCount); end
        for (int i = 0; i < 4; i++) begin
            tick(1, 0, 0, 0, 0, 0);
            checks++; if (PC !== exp_pc[i]) begin errors++; $display("FAIL boot_pc[%0d]: got %h exp %h", i, PC, exp_pc[i]); end
            checks++; if (PCPlus4 !== exp_pc[i] + 32'd4) begin errors++; $display("FAIL boot_pc4[%0d]: got %h exp %h", i, PCPlus4, exp_pc[i] + 32'd4); end
            checks++; if (FetchValid !== 1'b1) begin errors++; $display("FAIL boot_fv[%0d]: got %b exp 1", i, FetchValid); end
        end
    endtask

    task automatic test_branch;
        tick(1, 0, 1, 32'h40, 0, 0);
        checks++; if (PC !== 32'h40) begin errors++; $display("FAIL branch_pc: got %h exp 40", PC); end
        checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL branch_flush: got %b exp 1", Flush); end
        checks++; if (FetchValid !== 1'b0) begin errors++; $display("FAIL branch_fv: got %b exp 0", FetchValid); end
        checks++; if (RedirectCount !== 16'd1) begin errors++; $display("FAIL branch_cnt: got %0d exp 1", RedirectCount); end
        tick(1, 0, 0, 0, 0, 0);
        checks++; if (PC !== 32'h44) begin errors++; $display("FAIL branch_after_pc: got %h exp 44", PC); end
        checks++; if (Flush !== 1'b0 || FetchValid !== 1'b1) begin errors++; $display("FAIL branch_after_ctl: got flush=%b fv=%b exp 0/1", Flush, FetchValid); end
    endtask

    task automatic test_jump_priority;
        tick(1, 0, 1, 32'h40, 1, 32'h100);
        checks++; if (PC !== 32'h100) begin errors++; $display("FAIL jump_pc: got %h exp 100", PC); end
        checks++; if (RedirectCount !== 16'd2) begin errors++; $display("FAIL jump_cnt: got %0d exp 2", RedirectCount); end
        tick(1, 0, 0, 0, 0, 0);
        checks++; if (PC !== 32'h104) begin errors++; $display("FAIL jump_after_pc: got %h exp 104", PC); end
    endtask

    task automatic test_stall_pending;
        tick(1, 1, 1, 32'h80, 0, 0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick(1, 1, 0, 0, 0, 0);
            checks++; if (PC !== 32'h104) begin errors++; $display("FAIL stall_pc[%0d]: got %h exp 104", i, PC); end
            checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL stall_flush[%0d]: got %b exp 0", i, Flush); end
        end
        tick(1, 0, 0, 0, 0, 0);
        checks++; if (PC !== 32'h80) begin errors++; $display("FAIL release_pc: got %h exp 80", PC); end
        checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL release_flush: got %b exp 1", Flush); end
        checks++; if (RedirectCount !== 16'd3) begin errors++; $display("FAIL release_cnt: got %0d exp 3", RedirectCount); end
        tick(1, 0, 0, 0, 0, 0);
        checks++; if (PC !== 32'h84) begin errors++; $display("FAIL release_after_pc: got %h exp 84", PC); end
        // Newest buffered request replaces the older one.
        tick(1, 1, 1, 32'h200, 0, 0);
        tick(1, 1, 0, 0, 1, 32'h300);
        tick(1, 0, 0, 0, 0, 0);
        checks++; if (PC !== 32'h300) begin errors++; $display("FAIL overwrite_pc: got %h exp 300", PC); end
        checks++; if (RedirectCount !== 16'd4) begin errors++; $display("FAIL overwrite_cnt: got %0d exp 4", RedirectCount); end
    endtask

    task automatic test_reset_pending;
        logic [31:0] exp_pc[3] = '{32'h0, 32'h4, 32'h8};
        tick(1, 1, 1, 32'h500, 0, 0);
        tick(0, 1, 1, 32'h500, 0, 0);
        checks++; if (PC !== 32'h0 || FetchValid !== 1'b0) begin errors++; $display("FAIL rstpend_pc: got pc=%h fv=%b exp 0/0", PC, FetchValid); end
        checks++; if (RedirectCount !== 16'd0) begin errors++; $display("FAIL rstpend_cnt: got %0d exp 0", RedirectCount); end
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 0, 0, 0);
            checks++; if (PC !== exp_pc[i]) begin errors++; $display("FAIL rstpend_after_pc[%0d]: got %h exp %h", i, PC, exp_pc[i]); end
            checks++; if (Flush !== 1'b0) begin errors++; $display("FAIL rstpend_flush[%0d]: got %b exp 0", i, Flush); end
        end
    endtask

    task automatic test_saturate_wrap;
        logic [1:0] exp_c2[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            tick(1, 0, 1, 32'h1000 + 32'(16 * i), 0, 0);
            checks++; if (RedirectCount2 !== exp_c2[i]) begin errors++; $display("FAIL sat_cnt2[%0d]: got %0d exp %0d", i, RedirectCount2, exp_c2[i]); end
            checks++; if (RedirectCount !== 16'(i + 1)) begin errors++; $display("FAIL sat_cnt16[%0d]: got %0d exp %0d", i, RedirectCount, i + 1); end
            checks++; if (Flush !== 1'b1) begin errors++; $display("FAIL b2b_flush[%0d]: got %b exp 1", i, Flush); end
        end
        tick(1, 0, 1, 32'hFFFF_FFFB, 0, 0);
        checks++; if (PC !== 32'hFFFF_FFF8) begin errors++; $display("FAIL align_pc: got %h exp fffffff8", PC); end
        tick(1, 0, 0, 0, 0, 0);
        checks++; if (PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL top_pc: got %h exp fffffffc", PC); end
        checks++; if (PCPlus4 !== 32'h0) begin errors++; $display("FAIL top_pc4: got %h exp 0", PCPlus4); end
        tick(1, 0, 0, 0, 0, 0);
        checks++; if (PC !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h exp 0", PC); end
    endtask

    task automatic test_random;
        logic rst, stall, pcsrc, jump;
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 39) != 0);
            stall = ($urandom_range(0, 3) == 0);
            pcsrc = ($urandom_range(0, 4) == 0);
            jump  = ($urandom_range(0, 7) == 0);
            tick(rst, stall, pcsrc, $urandom, jump, $urandom);
            checks++; if (PC !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %h exp %h", i, PC, m_pc); end
            checks++; if (PCPlus4 !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pc4[%0d]: got %h exp %h", i, PCPlus4, m_pc + 32'd4); end
            checks++; if (FetchValid !== m_fv) begin errors++; $display("FAIL rnd_fv[%0d]: got %b exp %b", i, FetchValid, m_fv); end
            checks++; if (Flush !== m_flush) begin errors++; $display("FAIL rnd_flush[%0d]: got %b exp %b", i, Flush, m_flush); end
            checks++; if (RedirectCount !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d exp %0d", i, RedirectCount, m_cnt); end
            checks++; if (RedirectCount2 !== 2'(m_cnt2)) begin errors++; $display("FAIL rnd_cnt2[%0d]: got %0d exp %0d", i, RedirectCount2, m_cnt2); end
        end
    endtask

    initial begin
        m_pc = '0; m_fv = 0; m_flush = 0; m_boot = 1; m_pv = 0; m_pt = '0;
        m_cnt = 0; m_cnt2 = 0;
        test_reset;
        test_branch;
        test_jump_priority;
        test_stall_pending;
        test_reset_pending;
        test_saturate_wrap;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
